// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback requests, decode reservations and RF write port
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  localparam int NREG = 2 ** ADDR_W;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic              hazard0;
  logic              hazard1;
  logic              RegWrite;
  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] write_data;
  logic [NREG-1:0]   pending;
  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output rsv_valid, rsv_addr, rd_addr0, rd_addr1,
    input  req0_ready, req1_ready, hazard0, hazard1,
    input  RegWrite, write_register, write_data, pending
  );
  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  rsv_valid, rsv_addr, rd_addr0, rd_addr1,
    output req0_ready, req1_ready, hazard0, hazard1,
    output RegWrite, write_register, write_data, pending
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-requester RF write-port arbiter with pending-write scoreboard
module rf_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int RR_EN  = 1
) (
  input logic clk,
  input logic rst_n,
  rf_wb_arbiter_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;
  logic              ptr;
  logic              g0, g1, hs;
  logic [ADDR_W-1:0] hs_addr;
  logic [DATA_W-1:0] hs_data;
  logic [NREG-1:0]   set_v, clr_v;
  logic              reg_write;
  logic [ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic [NREG-1:0]   pend;
  // grant selection: req0 wins unless req1 also valid and pointer favours req1
  always_comb begin
    g0      = rst_n && bus.req0_valid && (!bus.req1_valid || !ptr || RR_EN == 0);
    g1      = rst_n && bus.req1_valid && !g0;
    hs      = g0 || g1;
    hs_addr = g0 ? bus.req0_addr : bus.req1_addr;
    hs_data = g0 ? bus.req0_data : bus.req1_data;
    set_v   = bus.rsv_valid ? NREG'(1) << bus.rsv_addr : '0;
    clr_v   = hs ? NREG'(1) << hs_addr : '0;
  end
  // pointer, registered RF write port and scoreboard; a set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= 1'b0;
      reg_write <= 1'b0;
      wr_reg    <= '0;
      wr_data   <= '0;
      pend      <= '0;
    end else begin
      if (hs && RR_EN != 0) ptr <= g0;
      reg_write <= hs;
      if (hs) begin
        wr_reg  <= hs_addr;
        wr_data <= hs_data;
      end
      pend <= set_v | (pend & ~clr_v);
    end
  end
  assign bus.req0_ready     = g0;
  assign bus.req1_ready     = g1;
  assign bus.RegWrite       = reg_write;
  assign bus.write_register = wr_reg;
  assign bus.write_data     = wr_data;
  assign bus.pending        = pend;
  assign bus.hazard0        = pend[bus.rd_addr0];
  assign bus.hazard1        = pend[bus.rd_addr1];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed checks of round-robin and fixed-priority arbiters
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;
  rf_wb_arbiter_if ia ();
  rf_wb_arbiter_if ib ();
  rf_wb_arbiter #(.RR_EN(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  rf_wb_arbiter #(.RR_EN(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic idle_a();
    ia.req0_valid = 0; ia.req0_addr = 0; ia.req0_data = 0;
    ia.req1_valid = 0; ia.req1_addr = 0; ia.req1_data = 0;
    ia.rsv_valid = 0; ia.rsv_addr = 0; ia.rd_addr0 = 0; ia.rd_addr1 = 0;
  endtask
  task automatic idle_b();
    ib.req0_valid = 0; ib.req0_addr = 0; ib.req0_data = 0;
    ib.req1_valid = 0; ib.req1_addr = 0; ib.req1_data = 0;
    ib.rsv_valid = 0; ib.rsv_addr = 0; ib.rd_addr0 = 0; ib.rd_addr1 = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask
  initial begin
    idle_a();
    idle_b();
    rst_n = 0;
    ia.req0_valid = 1; ia.req1_valid = 1;
    ib.req0_valid = 1; ib.req1_valid = 1;
    #1;
    chk("rst_ready_a", {ia.req0_ready, ia.req1_ready}, 2'b00);
    chk("rst_ready_b", {ib.req0_ready, ib.req1_ready}, 2'b00);
    step();
    step();
    chk("rst_regwrite", ia.RegWrite, 0);
    chk("rst_pending", ia.pending, 8'h00);
    chk("rst_wr", {ia.write_register, ia.write_data}, 0);
    rst_n = 1;
    idle_a();
    idle_b();
    step();
    chk("post_rst_regwrite", ia.RegWrite, 0);
    chk("post_rst_pending", ia.pending, 8'h00);
    ia.req0_valid = 1; ia.req0_addr = 3; ia.req0_data = 16'hA5A5;
    #1;
    chk("single_ready", {ia.req0_ready, ia.req1_ready}, 2'b10);
    step();
    ia.req0_valid = 0;
    chk("single_regwrite", ia.RegWrite, 1);
    chk("single_addr", ia.write_register, 3);
    chk("single_data", ia.write_data, 16'hA5A5);
    chk("single_pending", ia.pending, 8'h00);
    step();
    chk("single_idle", ia.RegWrite, 0);
    chk("single_hold", {ia.write_register, ia.write_data}, {3'd3, 16'hA5A5});
    do_reset();
    step();
    ia.req0_valid = 1; ia.req0_addr = 1; ia.req0_data = 16'h1111;
    ia.req1_valid = 1; ia.req1_addr = 2; ia.req1_data = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_ready%0d", k), {ia.req0_ready, ia.req1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k > 0) chk($sformatf("rr_write%0d", k), {ia.RegWrite, ia.write_register, ia.write_data},
                     (k % 2 == 1) ? {1'b1, 3'd1, 16'h1111} : {1'b1, 3'd2, 16'h2222});
      step();
    end
    idle_a();
    chk("rr_last_write", {ia.RegWrite, ia.write_register, ia.write_data}, {1'b1, 3'd2, 16'h2222});
    step();
    chk("rr_idle", ia.RegWrite, 0);
    ib.req0_valid = 1; ib.req0_addr = 1; ib.req0_data = 16'h1010;
    ib.req1_valid = 1; ib.req1_addr = 7; ib.req1_data = 16'h7070;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("fp_ready%0d", k), {ib.req0_ready, ib.req1_ready}, 2'b10);
      step();
    end
    ib.req0_valid = 0;
    #1;
    chk("fp_req1_ready", {ib.req0_ready, ib.req1_ready}, 2'b01);
    step();
    ib.req1_valid = 0;
    chk("fp_req1_write", {ib.RegWrite, ib.write_register, ib.write_data}, {1'b1, 3'd7, 16'h7070});
    step();
    chk("fp_idle", ib.RegWrite, 0);
    ia.rsv_valid = 1; ia.rsv_addr = 5; ia.rd_addr0 = 5; ia.rd_addr1 = 4;
    #1;
    chk("sb_hazard_before", ia.hazard0, 0);
    step();
    ia.rsv_valid = 0;
    #1;
    chk("sb_pending_set", ia.pending, 8'h20);
    chk("sb_hazard0", ia.hazard0, 1);
    chk("sb_hazard1", ia.hazard1, 0);
    ia.req1_valid = 1; ia.req1_addr = 5; ia.req1_data = 16'hBEEF;
    #1;
    chk("sb_req1_ready", ia.req1_ready, 1);
    chk("sb_hazard_same_cycle", ia.hazard0, 1);
    step();
    ia.req1_valid = 0;
    chk("sb_pending_clr", ia.pending, 8'h00);
    chk("sb_hazard_clr", ia.hazard0, 0);
    chk("sb_write", {ia.RegWrite, ia.write_register, ia.write_data}, {1'b1, 3'd5, 16'hBEEF});
    ia.rsv_valid = 1; ia.rsv_addr = 6;
    step();
    chk("sc_pending6", ia.pending, 8'h40);
    ia.req0_valid = 1; ia.req0_addr = 6; ia.req0_data = 16'h6666;
    #1;
    chk("sc_ready", ia.req0_ready, 1);
    step();
    ia.rsv_valid = 0; ia.req0_valid = 0;
    chk("sc_pending_kept", ia.pending, 8'h40);
    chk("sc_write", {ia.RegWrite, ia.write_register, ia.write_data}, {1'b1, 3'd6, 16'h6666});
    ia.req1_valid = 1; ia.req1_addr = 6; ia.req1_data = 16'h0606;
    step();
    ia.req1_valid = 0;
    chk("sc_pending_clr", ia.pending, 8'h00);
    ia.req0_valid = 1; ia.req0_addr = 0; ia.req0_data = 16'h0A0A;
    ia.req1_valid = 1; ia.req1_addr = 0; ia.req1_data = 16'h0B0B;
    #1;
    chk("same_dst_first", {ia.req0_ready, ia.req1_ready}, 2'b10);
    step();
    ia.req0_valid = 0;
    #1;
    chk("same_dst_second", {ia.req0_ready, ia.req1_ready}, 2'b01);
    chk("same_dst_w0", {ia.RegWrite, ia.write_register, ia.write_data}, {1'b1, 3'd0, 16'h0A0A});
    step();
    ia.req1_valid = 0;
    chk("same_dst_w1", {ia.RegWrite, ia.write_register, ia.write_data}, {1'b1, 3'd0, 16'h0B0B});
    ia.req0_valid = 1; ia.req0_addr = 2; ia.req0_data = 16'hDEAD;
    #1;
    chk("inflight_ready", ia.req0_ready, 1);
    rst_n = 0;
    step();
    ia.req0_valid = 0;
    chk("inflight_dropped", {ia.RegWrite, ia.write_register, ia.write_data}, 0);
    rst_n = 1;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
